dac_ramp_tx: RTL and testbench

Output-side counterpart of the AD9248 capture/filter path. Accepts 14-bit target codes over a valid/ready handshake and drives a parallel DAC with a free-running DAC clock. The output code slews toward each new target by at most a programmable step per DAC update, so setpoint changes never produce full-scale glitches. Sits between the control logic and the board DAC pins, mirroring how `adc_filter` sits between the ADC pins and the control logic.

---
 rtl/dac_pkg.sv | 13 +
 rtl/dac_ramp_tx_if.sv | 23 ++
 rtl/dac_tick_gen.sv | 38 +++
 rtl/dac_ramp_tx.sv | 105 ++++++++++
 tb/tb_dac_ramp_tx.sv | 313 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dac_pkg.sv
// Shared definitions for the DAC output ramp path: FSM state encoding,
// default data width and the midscale reset code.
package dac_pkg;

    localparam int DAC_W          = 14;
    localparam int DAC_RESET_CODE = 8192;

    typedef enum logic {
        IDLE = 1'b0,
        RAMP = 1'b1
    } state_t;

endpackage

// File: rtl/dac_ramp_tx_if.sv
// Target-code handshake between the control logic (master) and the DAC
// ramp transmitter (slave).
interface dac_ramp_tx_if #(
    parameter int N = dac_pkg::DAC_W
) ();

    logic [N-1:0] target_data;
    logic         target_valid;
    logic         target_ready;

    modport master (
        output target_data,
        output target_valid,
        input  target_ready
    );

    modport slave (
        input  target_data,
        input  target_valid,
        output target_ready
    );

endinterface

// File: rtl/dac_tick_gen.sv
// Free-running DAC update divider. Produces a one-cycle tick on the last
// clk of every DIV-cycle period and a registered 50% duty DAC latch clock
// that is low in the first half of each period and high in the second.
module dac_tick_gen #(
    parameter int DIV = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    output logic tick_o,
    output logic dac_clk_o
);

    localparam int CW = $clog2(DIV);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          dac_clk_q;

    // Wrap the counter after DIV-1; tick marks that final cycle.
    always_comb begin
        tick_o = (cnt_q == CW'(DIV - 1));
        cnt_d  = tick_o ? '0 : cnt_q + 1'b1;
    end

    // dac_clk is derived from the upcoming count so it is a clean flop output.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q     <= '0;
            dac_clk_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            dac_clk_q <= (cnt_d >= CW'(DIV / 2));
        end
    end

    assign dac_clk_o = dac_clk_q;

endmodule

// File: rtl/dac_ramp_tx.sv
// Slew-limited parallel DAC driver. Accepts target codes over a valid/ready
// handshake and moves dac_data toward the target by at most `step` codes per
// DAC update (step == 0 jumps directly). dac_data only changes on the edge
// after a divider tick, so it is stable while dac_clk is high.
// Optional build macro: DAC_RETARGET_EN -- keep accepting targets while a
// ramp is in progress; the ramp redirects from the current code.
module dac_ramp_tx
    import dac_pkg::*;
#(
    parameter int N          = DAC_W,
    parameter int DIV        = 4,
    parameter int RESET_CODE = DAC_RESET_CODE
) (
    input  logic                clk,
    input  logic                sys_rst,
    dac_ramp_tx_if.slave        tgt_bus,
    input  logic [N-1:0]        step,
    output logic [N-1:0]        dac_data,
    output logic                dac_clk,
    output logic                busy,
    output logic                at_target
);

    localparam logic [N-1:0] RST_V = N'(RESET_CODE);

    state_t       state_q, state_d;
    logic [N-1:0] dac_q, dac_d;
    logic [N-1:0] tgt_q, tgt_d;
    logic         tick;
    logic         accept;
    logic [N:0]   diff;
    logic [N:0]   mag;

    dac_tick_gen #(
        .DIV (DIV)
    ) u_tick_gen (
        .clk_i     (clk),
        .rst_i     (sys_rst),
        .tick_o    (tick),
        .dac_clk_o (dac_clk)
    );

    // Handshake readiness: always open with retargeting, otherwise idle-only.
    always_comb begin
`ifdef DAC_RETARGET_EN
        tgt_bus.target_ready = 1'b1;
`else
        tgt_bus.target_ready = (state_q == IDLE);
`endif
    end

    // Signed distance to the current target and its magnitude (N+1 bits).
    always_comb begin
        diff = {1'b0, tgt_q} - {1'b0, dac_q};
        mag  = diff[N] ? (~diff + 1'b1) : diff;
    end

    // Next code/target/state. A tick steps toward the target held before this
    // edge; a same-cycle acceptance only replaces the target for later ticks.
    // Leaving RAMP is decided on the resulting code vs resulting target, which
    // covers normal completion and a retarget onto the present code alike.
    always_comb begin
        state_d = state_q;
        dac_d   = dac_q;
        tgt_d   = tgt_q;
        accept  = tgt_bus.target_valid && tgt_bus.target_ready;

        if ((state_q == RAMP) && tick) begin
            if ((step == '0) || (mag <= {1'b0, step})) begin
                dac_d = tgt_q;
            end else if (diff[N]) begin
                dac_d = dac_q - step;
            end else begin
                dac_d = dac_q + step;
            end
        end

        if (accept) begin
            tgt_d = tgt_bus.target_data;
        end

        state_d = (dac_d == tgt_d) ? IDLE : RAMP;
    end

    // State, code and target registers; reset parks at midscale, idle.
    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q <= IDLE;
            dac_q   <= RST_V;
            tgt_q   <= RST_V;
        end else begin
            state_q <= state_d;
            dac_q   <= dac_d;
            tgt_q   <= tgt_d;
        end
    end

    // Status outputs decoded from the registered state.
    always_comb begin
        dac_data  = dac_q;
        busy      = (state_q == RAMP);
        at_target = (state_q == IDLE) && (dac_q == tgt_q);
    end

endmodule

// File: tb/tb_dac_ramp_tx.sv
// Self-checking bench for dac_ramp_tx (N=14, DIV=4, RESET_CODE=8192).
// Expected codes come from a reference that lists the full sequence of codes
// a ramp visits and places update k on the k-th DIV boundary after acceptance.
module tb_dac_ramp_tx;

    localparam int DIV = 4;

    logic        clk;
    logic        sys_rst;
    logic [13:0] step_r;
    logic [13:0] dac_data;
    logic        dac_clk;
    logic        busy;
    logic        at_target;

    dac_ramp_tx_if #(.N(14)) tif ();

    dac_ramp_tx #(
        .N          (14),
        .DIV        (DIV),
        .RESET_CODE (8192)
    ) dut (
        .clk       (clk),
        .sys_rst   (sys_rst),
        .tgt_bus   (tif),
        .step      (step_r),
        .dac_data  (dac_data),
        .dac_clk   (dac_clk),
        .busy      (busy),
        .at_target (at_target)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bench timeline: clock edges since reset release.
    int cyc;
    always @(posedge clk or posedge sys_rst) begin
        if (sys_rst) cyc <= 0;
        else         cyc <= cyc + 1;
    end

    int n_cmp = 0;
    int n_bad = 0;

    logic [13:0] model_dac;
    logic [13:0] exp_start;
    logic [13:0] exp_q[$];
    int          exp_first;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    // Build the list of codes visited from start to tgt with a fixed step.
    task automatic plan(input logic [13:0] start, input logic [13:0] tgt, input logic [13:0] stp);
        int c, t, s, d;
        c = int'(start);
        t = int'(tgt);
        s = int'(stp);
        exp_q.delete();
        while (c != t) begin
            d = (t > c) ? t - c : c - t;
            if (s == 0 || d <= s) c = t;
            else                  c = (t > c) ? c + s : c - s;
            exp_q.push_back(14'(c));
        end
        exp_start = start;
        exp_first = 32'h3fff_ffff;
    endtask

    function automatic int next_boundary(input int acc);
        return (acc / DIV + 1) * DIV;
    endfunction

    // Compare all outputs against the reference at the current negedge.
    task automatic check_now();
        int          k;
        logic [13:0] ec;
        logic        eb;
        if (exp_q.size() == 0 || cyc < exp_first) k = 0;
        else k = (cyc - exp_first) / DIV + 1;
        if (k > exp_q.size()) k = exp_q.size();
        ec = (k == 0) ? exp_start : exp_q[k-1];
        eb = (k < exp_q.size());
        check("dac_data", 32'(dac_data), 32'(ec));
        check("busy", 32'(busy), 32'(eb));
        check("at_target", 32'(at_target), 32'(!eb));
        check("dac_clk", 32'(dac_clk), 32'((cyc % DIV) >= DIV / 2));
`ifdef DAC_RETARGET_EN
        check("target_ready", 32'(tif.target_ready), 32'd1);
`else
        check("target_ready", 32'(tif.target_ready), 32'(!eb));
`endif
    endtask

    // Offer a target at a negedge; returns the cycle count right after the
    // accepting edge (-1 if never accepted). align places acceptance on a tick.
    task automatic send(input logic [13:0] d, input bit align, output int acc);
        int w;
        if (align) begin
            w = 0;
            while ((cyc % DIV) != DIV - 1 && w < DIV) begin
                @(negedge clk);
                w++;
            end
        end
        tif.target_valid = 1'b1;
        tif.target_data  = d;
        w = 0;
        while (!tif.target_ready && w < 400) begin
            @(negedge clk);
            w++;
        end
        if (!tif.target_ready) begin
            check("ready_timeout", 32'(tif.target_ready), 32'd1);
            tif.target_valid = 1'b0;
            acc = -1;
            return;
        end
        @(posedge clk);
        #1;
        acc = cyc;
        @(negedge clk);
        tif.target_valid = 1'b0;
    endtask

    // Follow a planned ramp to completion; count observed code changes.
    task automatic observe(output int nchg, output logic [13:0] fin);
        logic [13:0] prev;
        int          lim;
        prev = exp_start;
        nchg = 0;
        lim  = (exp_q.size() + 2) * DIV;
        for (int i = 0; i < lim; i++) begin
            check_now();
            if (dac_data !== prev) nchg++;
            prev = dac_data;
            @(negedge clk);
        end
        check_now();
        fin = dac_data;
        if (exp_q.size() != 0) model_dac = exp_q[exp_q.size()-1];
    endtask

    task automatic run_ramp(input logic [13:0] t, input logic [13:0] s, input bit align,
                            output int nchg, output logic [13:0] fin);
        int acc;
        plan(model_dac, t, s);
        step_r = s;
        send(t, align, acc);
        exp_first = next_boundary(acc);
        observe(nchg, fin);
    endtask

    // Pulse reset between clock edges and confirm outputs clear asynchronously.
    task automatic pulse_reset(input string tag);
        #2 sys_rst = 1'b1;
        #1;
        check({tag, "_rst_dac"}, 32'(dac_data), 32'd8192);
        check({tag, "_rst_busy"}, 32'(busy), 32'd0);
        check({tag, "_rst_dacclk"}, 32'(dac_clk), 32'd0);
        check({tag, "_rst_at_target"}, 32'(at_target), 32'd1);
        check({tag, "_rst_ready"}, 32'(tif.target_ready), 32'd1);
        @(negedge clk);
        sys_rst = 1'b0;
        model_dac = 14'd8192;
        plan(14'd8192, 14'd8192, 14'd0);
    endtask

    typedef struct {
        logic [13:0] tgt;
        logic [13:0] stp;
        bit          align;
        int          exp_updates;
        logic [13:0] exp_final;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int          nchg, acc, lim;
        logic [13:0] fin, t, s;
        bit          got;

        // Sequential table: each row starts from the previous row's final code.
        vecs[0] = '{tgt: 14'd8500,  stp: 14'd100,   align: 1'b0, exp_updates: 4, exp_final: 14'd8500};
        vecs[1] = '{tgt: 14'd0,     stp: 14'd0,     align: 1'b1, exp_updates: 1, exp_final: 14'd0};
        vecs[2] = '{tgt: 14'd16383, stp: 14'd4096,  align: 1'b0, exp_updates: 4, exp_final: 14'd16383};
        vecs[3] = '{tgt: 14'd16383, stp: 14'd5,     align: 1'b0, exp_updates: 0, exp_final: 14'd16383};
        vecs[4] = '{tgt: 14'd8192,  stp: 14'd16383, align: 1'b1, exp_updates: 1, exp_final: 14'd8192};
        vecs[5] = '{tgt: 14'd8191,  stp: 14'd1,     align: 1'b0, exp_updates: 1, exp_final: 14'd8191};
        vecs[6] = '{tgt: 14'd8000,  stp: 14'd64,    align: 1'b1, exp_updates: 3, exp_final: 14'd8000};

        sys_rst          = 1'b1;
        tif.target_valid = 1'b0;
        tif.target_data  = '0;
        step_r           = '0;
        model_dac        = 14'd8192;
        plan(14'd8192, 14'd8192, 14'd0);

        repeat (2) @(negedge clk);
        check("reset_dac", 32'(dac_data), 32'd8192);
        check("reset_at_target", 32'(at_target), 32'd1);
        check("reset_ready", 32'(tif.target_ready), 32'd1);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_dacclk", 32'(dac_clk), 32'd0);
        sys_rst = 1'b0;

        // Idle after reset: dac_clk period DIV, high for DIV/2.
        for (int i = 0; i < 3 * DIV; i++) begin
            @(negedge clk);
            check_now();
        end

        for (int v = 0; v < 7; v++) begin
            run_ramp(vecs[v].tgt, vecs[v].stp, vecs[v].align, nchg, fin);
            check($sformatf("vec%0d_updates", v), 32'(nchg), 32'(vecs[v].exp_updates));
            check($sformatf("vec%0d_final", v), 32'(fin), 32'(vecs[v].exp_final));
        end

        // Reset mid-ramp once dac_data has reached 8492, during dac_clk high.
        pulse_reset("pre");
        plan(14'd8192, 14'd9000, 14'd100);
        step_r = 14'd100;
        send(14'd9000, 1'b0, acc);
        exp_first = next_boundary(acc);
        lim = 0;
        while (dac_data !== 14'd8492 && lim < 40) begin
            check_now();
            @(negedge clk);
            lim++;
        end
        check("midramp_reached_8492", 32'(dac_data), 32'd8492);
        repeat (2) begin
            @(negedge clk);
            check_now();
        end
        pulse_reset("midramp");

`ifndef DAC_RETARGET_EN
        // Second target held through a ramp; accepted one cycle after arrival.
        plan(14'd8192, 14'd9000, 14'd50);
        step_r = 14'd50;
        send(14'd9000, 1'b0, acc);
        exp_first = next_boundary(acc);
        tif.target_valid = 1'b1;
        tif.target_data  = 14'd1000;
        got = 1'b0;
        lim = (exp_q.size() + 2) * DIV;
        for (int i = 0; i < lim; i++) begin
            check_now();
            if (tif.target_ready) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("held_ready_seen", 32'(got), 32'd1);
        @(posedge clk);
        #1;
        check("held_accept_cycle", 32'(cyc),
              32'(exp_first + (exp_q.size() - 1) * DIV + 1));
        acc = cyc;
        @(negedge clk);
        tif.target_valid = 1'b0;
        model_dac = 14'd9000;
        plan(14'd9000, 14'd1000, 14'd50);
        exp_first = next_boundary(acc);
        observe(nchg, fin);
        check("held_descent_final", 32'(fin), 32'd1000);
        check("held_descent_updates", 32'(nchg), 32'd160);
`else
        // Retarget mid-ramp: redirect from 8392 toward 8000.
        plan(14'd8192, 14'd9000, 14'd100);
        step_r = 14'd100;
        send(14'd9000, 1'b0, acc);
        exp_first = next_boundary(acc);
        lim = 0;
        while (dac_data !== 14'd8392 && lim < 40) begin
            check_now();
            @(negedge clk);
            lim++;
        end
        check("retarget_reached_8392", 32'(dac_data), 32'd8392);
        model_dac = 14'd8392;
        plan(14'd8392, 14'd8000, 14'd100);
        send(14'd8000, 1'b0, acc);
        exp_first = next_boundary(acc);
        observe(nchg, fin);
        check("retarget_updates", 32'(nchg), 32'd4);
        check("retarget_final", 32'(fin), 32'd8000);
`endif

        // Randomized ramps with random idle gaps (random tick phase at accept).
        for (int r = 0; r < 25; r++) begin
            repeat ($urandom_range(0, 5)) @(negedge clk);
            t = ($urandom_range(0, 5) == 0) ? model_dac : 14'($urandom_range(0, 16383));
            s = ($urandom_range(0, 4) == 0) ? 14'd0 : 14'($urandom_range(300, 4000));
            run_ramp(t, s, 1'b0, nchg, fin);
            check($sformatf("rand%0d_final", r), 32'(fin), 32'(t));
            check($sformatf("rand%0d_updates", r), 32'(nchg), 32'(exp_q.size()));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
